// File: rtl/rf_sched_pkg.sv
// rf_sched_pkg: shared widths, types and constants for the register-file write scheduler.
package rf_sched_pkg;
  localparam int DEF_XLEN = 32;
  localparam int DEF_AW = 5;
  typedef logic [DEF_AW-1:0] reg_addr_t;
  typedef logic [DEF_XLEN-1:0] xlen_t;
  localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/rf_write_scheduler_if.sv
// rf_write_scheduler_if: pipeline, long-latency, decode and register-file write-port signals.
interface rf_write_scheduler_if
  import rf_sched_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int AW = DEF_AW,
  parameter int CW = 2
);
  logic wb_valid;
  logic [AW-1:0] wb_dest;
  logic [XLEN-1:0] wb_data;
  logic ll_issue_valid;
  logic [AW-1:0] ll_issue_dest;
  logic ll_valid;
  logic ll_ready;
  logic [AW-1:0] ll_dest;
  logic [XLEN-1:0] ll_data;
  logic [AW-1:0] rs1_addr;
  logic [AW-1:0] rs2_addr;
  logic rs1_busy;
  logic rs2_busy;
  logic dest_busy;
  logic stall_req;
  logic rf_write;
  logic [AW-1:0] rf_dest_addr;
  logic [XLEN-1:0] rf_data;
  logic [CW-1:0] ll_count;
  modport master (
    output wb_valid, wb_dest, wb_data, ll_issue_valid, ll_issue_dest, ll_valid, ll_dest, ll_data,
           rs1_addr, rs2_addr,
    input  ll_ready, rs1_busy, rs2_busy, dest_busy, stall_req, rf_write, rf_dest_addr, rf_data, ll_count
  );
  modport slave (
    input  wb_valid, wb_dest, wb_data, ll_issue_valid, ll_issue_dest, ll_valid, ll_dest, ll_data,
           rs1_addr, rs2_addr,
    output ll_ready, rs1_busy, rs2_busy, dest_busy, stall_req, rf_write, rf_dest_addr, rf_data, ll_count
  );
endinterface

// File: rtl/rf_sched_fifo.sv
// rf_sched_fifo: synchronous FIFO; push ignored when full, pop ignored when empty.
module rf_sched_fifo #(
  parameter int W = 37,
  parameter int DEPTH = 2,
  parameter int CW = $clog2(DEPTH) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty,
  output logic [CW-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign full = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  assign dout = mem_q[rd_q];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din;
        wr_q <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/rf_write_scheduler.sv
// rf_write_scheduler: arbitrates the register-file write port between writeback and buffered long-latency results.
module rf_write_scheduler
  import rf_sched_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int AW = DEF_AW,
  parameter int LL_DEPTH = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic clk,
  input logic reset,
  rf_write_scheduler_if.slave bus
);
  localparam int CW = $clog2(LL_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int NR = 2 ** AW;
  logic [AW+XLEN-1:0] head;
  logic [AW-1:0] head_dest;
  logic [XLEN-1:0] head_data;
  logic full, empty, push, pop, wb_used, head_wr, blocked;
  logic [CW-1:0] count;
  logic [NR-1:0] pending_q, pending_d;
  logic [SW-1:0] starve_q, starve_d;
  logic stall_q, stall_d;
  assign {head_dest, head_data} = head;
  assign wb_used = bus.wb_valid && bus.wb_dest != AW'(REG_ZERO);
  assign pop = !wb_used && !empty;
  assign head_wr = pop && head_dest != AW'(REG_ZERO);
  assign push = bus.ll_valid && bus.ll_ready;
  assign blocked = !empty && !pop;
  assign bus.ll_ready = !full && !reset;
  assign bus.ll_count = count;
  assign bus.rf_write = !reset && (wb_used || head_wr);
  assign bus.rf_dest_addr = wb_used ? bus.wb_dest : head_wr ? head_dest : '0;
  assign bus.rf_data = wb_used ? bus.wb_data : head_wr ? head_data : '0;
  assign bus.rs1_busy = pending_q[bus.rs1_addr];
  assign bus.rs2_busy = pending_q[bus.rs2_addr];
  assign bus.dest_busy = pending_q[bus.ll_issue_dest];
  assign bus.stall_req = stall_q;
  rf_sched_fifo #(.W(AW + XLEN), .DEPTH(LL_DEPTH), .CW(CW)) u_fifo (
    .clk(clk),
    .rst(reset),
    .push(push),
    .pop(pop),
    .din({bus.ll_dest, bus.ll_data}),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  // A new issue to the register being committed this cycle keeps it pending.
  always_comb begin
    pending_d = pending_q;
    if (pop) pending_d[head_dest] = 1'b0;
    if (bus.ll_issue_valid) pending_d[bus.ll_issue_dest] = 1'b1;
    pending_d[0] = 1'b0;
  end
  assign starve_d = !blocked ? '0 : starve_q == SW'(STARVE_LIMIT - 1) ? starve_q : starve_q + 1'b1;
  assign stall_d = blocked && starve_q == SW'(STARVE_LIMIT - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
      starve_q <= '0;
      stall_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      starve_q <= starve_d;
      stall_q <= stall_d;
    end
  end
endmodule
